pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
Registered program-counter unit. It is the parametrised successor to the combinational branch-offset selector.
- Owns the PC register and a branch-offset LUT held in registers, reset-loaded and optionally run-time writable.
- Provides a call/return stack, a stall input, and error flags.
- Sits between the decoder (branch/call/ret controls) and instruction ROM address.

Parameters:
- D, 12, PC and offset width in bits.
- LUT_N, 16, number of LUT offset entries.
- IDX_W, $clog2(LUT_N), width of pc_ctrl_input (LUT index or signed immediate).
- STK_N, 4, return-stack depth in entries.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold the PC and stack this cycle.
- branch_en  in  1  take a relative branch.
- immOrLUT  in  1  1 = offset is LUT[pc_ctrl_input]; 0 = sign-extended pc_ctrl_input.
- pc_ctrl_input  in  IDX_W  LUT index or signed immediate.
- call  in  1  branch and push the return address.
- ret  in  1  pop the return address into the PC.
- lut_we  in  1  LUT write enable (feature only).
- lut_waddr  in  IDX_W  LUT write index (feature only).
- lut_wdata  in  D  signed offset to write (feature only).
- pc  out  D  current PC (registered).
- stk_empty  out  1  stack holds 0 entries.
- stk_full  out  1  stack holds STK_N entries.
- stk_err  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - pc=0, stack pointer=0, stk_err=0.
  - So stk_empty=1 and stk_full=0.
  - LUT loaded from package constant PCSEQ_LUT_INIT.
  - Reset asserted mid-operation discards all state immediately.
- Offset:
  - immOrLUT=0: sign-extend pc_ctrl_input from IDX_W to D bits.
  - immOrLUT=1: LUT[pc_ctrl_input], a D-bit two's-complement value.
  - A LUT entry of 0 means "hold PC".
- All arithmetic is modulo 2^D: pc+1 and pc+offset wrap silently, no flag.
- Next PC, one-cycle latency. Priority order, highest first:
  1. stall=1: pc, stack and stk_err unchanged; branch_en/call/ret ignored.
  2. ret=1, stack not empty: pc <= top of stack; pop.
  3. ret=1, stack empty: pc <= pc+1; stk_err <= 1.
  4. call=1, stack not full: push pc+1; pc <= pc+offset.
  5. call=1, stack full: pc <= pc+offset; no push; stk_err <= 1.
  6. branch_en=1: pc <= pc+offset.
  7. Otherwise: pc <= pc+1.
- When ret and call are both asserted, ret wins and call is ignored (no push).
- stk_err stays set until reset.
- Stack is LIFO over STK_N registers with a pointer 0..STK_N; no wrap.
- LUT writes:
  - Take effect at the clock edge and are independent of stall.
  - A read of the same index in the same cycle sees the old value.
  - lut_waddr >= LUT_N: write ignored.
  - A read index >= LUT_N yields offset 0.

Optional Feature:
- Macro: PCSEQ_LUT_WR_EN.
- Defined: lut_we/lut_waddr/lut_wdata are functional as described above.
- Undefined:
  - Ports remain but are ignored.
  - LUT is constant PCSEQ_LUT_INIT; synthesis infers no LUT registers (constant ROM).

Decomposition:
- Package pc_seq_pkg holds:
  - default parameters;
  - PCSEQ_LUT_INIT array of LUT_N x D signed offsets (unlisted entries 0);
  - enum next_sel_e {SEL_HOLD, SEL_RET, SEL_CALL, SEL_BR, SEL_INC}.
- One sub-module, pc_ret_stack: push/pop/full/empty/overflow/underflow, parametrised by D and STK_N.
- Priority logic and LUT stay in pc_sequencer.

Test Plan:
- Reset, then 5 idle cycles -> pc = 0,1,2,3,4,5; stk_empty=1; stk_err=0.
- pc=20, branch_en=1, immOrLUT=0, pc_ctrl_input=4'b1110 (-2) -> pc=18 next cycle; with D=12, pc=4095 idle -> pc=0.
- PCSEQ_LUT_WR_EN defined:
  - lut_we writes idx 3 = 12'hF9B (-101); same cycle branch via LUT idx 3 -> uses old value.
  - Next cycle at pc=200, a branch via LUT idx 3 -> pc=99.
- call at pc=10 with offset +20 -> pc=30 and stack top=11; ret at pc=31 -> pc=11, stk_empty=1.
- Five calls, STK_N=4 -> stk_full after 4th; 5th still jumps, stk_err=1. Then five rets -> 4 pops in LIFO order, 5th gives pc+1.
- stall held 3 cycles with branch_en=1 -> pc constant. Reset_n pulsed low mid-call -> pc=0, stack empty immediately (asynchronous).

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: default sizes,
// the reset contents of the branch-offset LUT and the next-PC select codes.
package pc_seq_pkg;

    localparam int PCSEQ_D      = 12;
    localparam int PCSEQ_LUT_N  = 16;
    localparam int PCSEQ_STK_N  = 4;
    localparam int PCSEQ_LUT_AW = $clog2(PCSEQ_LUT_N);

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_RET,
        SEL_CALL,
        SEL_BR,
        SEL_INC
    } next_sel_e;

    // Signed branch offsets loaded at reset; entry 0 holds the PC in place.
    localparam logic signed [PCSEQ_D-1:0] PCSEQ_LUT_INIT [PCSEQ_LUT_N] = '{
        12'sd0,   12'sd4,   -12'sd4,  12'sd16,
        -12'sd16, 12'sd20,  12'sd0,   12'sd0,
        12'sd0,   12'sd0,   12'sd0,   12'sd0,
        12'sd0,   12'sd0,   12'sd0,   12'sd0
    };

    // Sign-extended initial offset for any index; entries past the table are 0
    // so instances with a larger LUT_N still get a defined reset value.
    function automatic logic signed [31:0] lut_init(input int idx);
        logic signed [31:0] v;
        v = '0;
        if (idx >= 0 && idx < PCSEQ_LUT_N) begin
            v = 32'(PCSEQ_LUT_INIT[idx[PCSEQ_LUT_AW-1:0]]);
        end
        return v;
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// LIFO return-address stack. The pointer counts stored entries (0..STK_N)
// and never wraps; pushes when full and pops when empty are dropped and
// reported on overflow/underflow for the caller to latch.
module pc_ret_stack #(
    parameter int D     = 12,
    parameter int STK_N = 4
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [D-1:0] push_data,
    output logic [D-1:0] top,
    output logic         empty,
    output logic         full,
    output logic         overflow,
    output logic         underflow
);

    localparam int PTR_W = $clog2(STK_N + 1);
    localparam int AW    = (STK_N > 1) ? $clog2(STK_N) : 1;

    logic [STK_N-1:0][D-1:0] mem;
    logic [PTR_W-1:0]        ptr;
    logic [AW-1:0]           wr_idx;
    logic [AW-1:0]           top_idx;

    assign empty     = (ptr == '0);
    assign full      = (ptr == PTR_W'(STK_N));
    assign overflow  = push && full;
    assign underflow = pop && empty;
    assign wr_idx    = AW'(ptr);
    assign top_idx   = AW'(ptr - 1'b1);

    // Pointer moves by one per accepted operation; pop takes precedence.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr <= '0;
        end else if (pop && !empty) begin
            ptr <= ptr - 1'b1;
        end else if (push && !full) begin
            ptr <= ptr + 1'b1;
        end
    end

    // Entry storage; contents above the pointer are don't-care, so no reset.
    always_ff @(posedge Clk) begin
        if (push && !full && !pop) begin
            mem[wr_idx] <= push_data;
        end
    end

    // Top-of-stack read, forced to zero when nothing is stored.
    always_comb begin
        top = '0;
        if (!empty) begin
            top = mem[top_idx];
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with relative branch, call/return stack,
// stall and sticky stack-error flag. Branch offsets come either from a
// sign-extended immediate or from a LUT of signed offsets.
// Build option: define PCSEQ_LUT_WR_EN to make the LUT run-time writable
// through lut_we/lut_waddr/lut_wdata; otherwise the LUT is a constant ROM
// and those ports are ignored.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int D     = PCSEQ_D,
    parameter int LUT_N = PCSEQ_LUT_N,
    parameter int IDX_W = $clog2(LUT_N),
    parameter int STK_N = PCSEQ_STK_N
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             stall,
    input  logic             branch_en,
    input  logic             immOrLUT,
    input  logic [IDX_W-1:0] pc_ctrl_input,
    input  logic             call,
    input  logic             ret,
    input  logic             lut_we,
    input  logic [IDX_W-1:0] lut_waddr,
    input  logic [D-1:0]     lut_wdata,
    output logic [D-1:0]     pc,
    output logic             stk_empty,
    output logic             stk_full,
    output logic             stk_err
);

    logic [LUT_N-1:0][D-1:0] lut_rst;
    logic [LUT_N-1:0][D-1:0] lut_q;
    logic [D-1:0]            lut_rd;
    logic [D-1:0]            offset;
    logic [D-1:0]            pc_inc;
    logic [D-1:0]            pc_nxt;
    logic [D-1:0]            stk_top;
    logic                    stk_push;
    logic                    stk_pop;
    logic                    stk_ovf;
    logic                    stk_udf;
    next_sel_e               sel;

    for (genvar g = 0; g < LUT_N; g++) begin : g_lut_rst
        assign lut_rst[g] = D'(lut_init(g));
    end

`ifdef PCSEQ_LUT_WR_EN
    // LUT registers: reset-loaded, written at the edge regardless of stall.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lut_q <= lut_rst;
        end else if (lut_we && (int'(lut_waddr) < LUT_N)) begin
            lut_q[lut_waddr] <= lut_wdata;
        end
    end
`else
    logic unused_lut_ports;

    assign lut_q            = lut_rst;
    assign unused_lut_ports = ^{lut_we, lut_waddr, lut_wdata};
`endif

    // LUT read; out-of-range indices give a zero offset (hold).
    always_comb begin
        lut_rd = '0;
        if (int'(pc_ctrl_input) < LUT_N) begin
            lut_rd = lut_q[pc_ctrl_input];
        end
    end

    assign offset = immOrLUT ? lut_rd
                             : {{(D-IDX_W){pc_ctrl_input[IDX_W-1]}}, pc_ctrl_input};
    assign pc_inc = pc + 1'b1;

    // Stack is frozen under stall; ret masks call so a combined request never pushes.
    assign stk_pop  = !stall && ret;
    assign stk_push = !stall && !ret && call;

    pc_ret_stack #(
        .D     (D),
        .STK_N (STK_N)
    ) u_stack (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_inc),
        .top       (stk_top),
        .empty     (stk_empty),
        .full      (stk_full),
        .overflow  (stk_ovf),
        .underflow (stk_udf)
    );

    // Next-PC source selection in priority order.
    always_comb begin
        sel = SEL_INC;
        if (stall) begin
            sel = SEL_HOLD;
        end else if (ret) begin
            sel = stk_empty ? SEL_INC : SEL_RET;
        end else if (call) begin
            sel = SEL_CALL;
        end else if (branch_en) begin
            sel = SEL_BR;
        end
    end

    // Next-PC value; all arithmetic wraps modulo 2^D.
    always_comb begin
        pc_nxt = pc_inc;
        unique case (sel)
            SEL_HOLD:         pc_nxt = pc;
            SEL_RET:          pc_nxt = stk_top;
            SEL_CALL, SEL_BR: pc_nxt = pc + offset;
            default:          pc_nxt = pc_inc;
        endcase
    end

    // PC register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pc <= '0;
        end else begin
            pc <= pc_nxt;
        end
    end

    // Sticky stack error, cleared only by reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stk_err <= 1'b0;
        end else if (stk_ovf || stk_udf) begin
            stk_err <= 1'b1;
        end
    end

endmodule
